// File: rtl/frame_buffer_arbiter_pkg.sv
// Shared definitions for the edge-detection pipeline: stage indices, frame-buffer
// geometry and the arbiter state encoding.
package edge_pkg;

  localparam int N_STAGES     = 5;
  localparam int FB_ADDR_W    = 17;
  localparam int FB_DATA_W    = 8;
  localparam int FB_MAX_BURST = 16;

  typedef enum logic [2:0] {
    STG_GAUSS  = 3'd0,
    STG_SOBEL  = 3'd1,
    STG_NMS    = 3'd2,
    STG_THRESH = 3'd3,
    STG_HYST   = 3'd4
  } stage_e;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/frame_buffer_arbiter_if.sv
// Stage-engine request bus plus frame-buffer SRAM port, as seen by the arbiter.
interface frame_buffer_arbiter_if
  import edge_pkg::*;
#(
  parameter int N_REQ  = N_STAGES,
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        we;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [N_REQ-1:0]        gnt;
  logic [DATA_W-1:0]       rdata;
  logic [N_REQ-1:0]        rvalid;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  // Engines plus SRAM side.
  modport master (
    output req, we, addr, wdata, mem_rdata,
    input  gnt, rdata, rvalid, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req, we, addr, wdata, mem_rdata,
    output gnt, rdata, rvalid, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/frame_buffer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: highest priority at (ptr+1) mod N_REQ, ptr itself
// lowest. mask_owner removes the requester at ptr from the candidate set.
module rr_arbiter
  import edge_pkg::*;
#(
  parameter int N_REQ = N_STAGES
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  input  logic                     mask_owner,
  output logic [N_REQ-1:0]         winner_oh,
  output logic [$clog2(N_REQ)-1:0] winner_idx,
  output logic                     valid
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req_m;
  logic [IDX_W-1:0] cand;

  always_comb begin
    req_m      = req;
    cand       = '0;
    winner_oh  = '0;
    winner_idx = '0;
    valid      = 1'b0;
    if (mask_owner) req_m[ptr] = 1'b0;
    // Walk from lowest to highest priority so the highest-priority hit is kept.
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(ptr) + i) % N_REQ);
      if (req_m[cand]) begin
        winner_idx = cand;
        valid      = 1'b1;
      end
    end
    if (valid) winner_oh[winner_idx] = 1'b1;
  end
endmodule

// File: rtl/frame_buffer_arbiter.sv
// Round-robin arbiter sharing the single-port frame buffer between the stage
// engines; bursts end on owner req drop or after MAX_BURST beats.
//
// state     | meaning
// ARB_IDLE  | no grant, bus quiet; grants when enable and any req
// ARB_OWNED | one engine owns the bus; a beat is any cycle with req[owner]
module frame_buffer_arbiter
  import edge_pkg::*;
#(
  parameter int N_REQ     = N_STAGES,
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W,
  parameter int MAX_BURST = FB_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  frame_buffer_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;

  logic              owner_req, owner_we, beat;
  logic [ADDR_W-1:0] owner_addr;
  logic [DATA_W-1:0] owner_wdata;
  logic [IDX_W-1:0]  arb_ptr;
  logic              mask_owner;
  logic [N_REQ-1:0]  win_oh;
  logic [IDX_W-1:0]  win_idx;
  logic              win_valid;

  always_comb begin
    owner_req   = 1'b0;
    owner_we    = 1'b0;
    owner_addr  = '0;
    owner_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        owner_req   = bus.req[i];
        owner_we    = bus.we[i];
        owner_addr  = bus.addr[i*ADDR_W +: ADDR_W];
        owner_wdata = bus.wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign beat = (state_q == ARB_OWNED) && owner_req;

  // While owned, any release ranks from the current owner, putting it last.
  assign arb_ptr    = (state_q == ARB_OWNED) ? owner_q : ptr_q;
  assign mask_owner = (state_q == ARB_OWNED) && !owner_req;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (bus.req),
    .ptr        (arb_ptr),
    .mask_owner (mask_owner),
    .winner_oh  (win_oh),
    .winner_idx (win_idx),
    .valid      (win_valid)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    rvalid_d = (beat && !owner_we) ? gnt_q : '0;
    case (state_q)
      ARB_IDLE: begin
        if (enable && win_valid) begin
          state_d = ARB_OWNED;
          gnt_d   = win_oh;
          owner_d = win_idx;
          cnt_d   = '0;
        end
      end
      ARB_OWNED: begin
        if (!beat || (cnt_q == CNT_LAST)) begin
          ptr_d = owner_q;
          cnt_d = '0;
          if (enable && win_valid) begin
            gnt_d   = win_oh;
            owner_d = win_idx;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_en    = beat;
  assign bus.mem_we    = beat && owner_we;
  assign bus.mem_addr  = beat ? owner_addr : '0;
  assign bus.mem_wdata = beat ? owner_wdata : '0;
endmodule

// File: doc/frame_buffer_arbiter.md
# frame_buffer_arbiter

Round-robin arbiter sharing the single-port on-chip frame buffer between the five edge-detection stage engines (Gaussian, Sobel, suppression, thresholding, hysteresis). Each engine issues word-wide read/write beats in bursts; the arbiter grants one engine at a time, muxes its request onto the SRAM port, and routes read data back. It sits between the stage engines and the frame-buffer SRAM, beside the pipeline control unit.

## Interface
- N_REQ, 5, number of requesters (index = stage number from the shared package)
- ADDR_W, 17, frame-buffer word address width
- DATA_W, 8, pixel/word width
- MAX_BURST, 16, maximum consecutive beats per grant (power of two, ≥2)

- clk  in  1  system clock; one clock domain
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  when low, no new grant is issued; the current burst runs to release
- req  in  N_REQ  per-requester access request; held high for each desired beat
- we  in  N_REQ  per-requester write strobe, qualified by req
- addr  in  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_REQ*DATA_W  packed write data
- gnt  out  N_REQ  registered one-hot grant (all-zero when idle)
- rdata  out  DATA_W  read data broadcast, valid where rvalid set
- rvalid  out  N_REQ  one-hot; high one cycle after requester's read beat
- mem_en, mem_we  out  1  SRAM enable / write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, one-cycle latency after mem_en & !mem_we

## Operation
- States: IDLE (gnt=0) and OWNED (exactly one gnt bit set, owner index o).
- Beat: any cycle with gnt[o] & req[o]. During a beat mem_en=1, mem_we=we[o], mem_addr/mem_wdata = owner's slice, all combinational from registered gnt. Outside beats mem_en=mem_we=0, mem_addr=0, mem_wdata=0.
- Winner selection: round-robin over req, highest priority at (ptr+1) mod N_REQ, ptr = last owner (reset 0, so requester 1 wins first when all request).
- IDLE → OWNED when enable & |req: gnt registers winner next cycle; beat_cnt cleared.
- OWNED release conditions, evaluated each cycle:
  - voluntary: req[o]=0 → no beat this cycle; next cycle gnt = winner of current req if enable, else IDLE. Costs one idle bus cycle.
  - exhaustion: beat with beat_cnt==MAX_BURST-1 → next gnt = winner with o at lowest priority; if o is sole requester it is re-granted, beat_cnt cleared. No idle cycle.
- Otherwise OWNED holds, beat_cnt increments on each beat (width $clog2(MAX_BURST), no wrap beyond release).
- ptr updates to o on every release.
- enable low: current owner keeps bus until a release condition; then IDLE. enable never truncates a burst.
- Read return: registered read-beat owner one-hot drives rvalid next cycle; rdata = mem_rdata passthrough.
- Requesters may change addr/we/wdata every beat; arbiter does no address incrementing.

## Timing
- Reset values: gnt=0, rvalid=0, state IDLE, ptr=0, beat_cnt=0; mem_en=0 (combinational, follows gnt=0).
- Request-to-grant latency: 1 cycle from IDLE; first beat in the cycle gnt rises (if req still high).
- Read latency: beat cycle N → rvalid/rdata cycle N+1.
- Back-to-back read bursts from different owners: rvalid of old owner's last beat and new owner's first beat in consecutive cycles, never overlapping.
- Reset asserted mid-burst: gnt, rvalid clear immediately (async); a read beat in flight produces no rvalid.
- Simultaneous req drop by owner and new req elsewhere in same cycle: new winner granted next cycle.

## Structure
- Shared package edge_pkg: N_STAGES=5, FB_ADDR_W, FB_DATA_W, stage index enum (STG_GAUSS=0, STG_SOBEL=1, STG_NMS=2, STG_THRESH=3, STG_HYST=4), arbiter state typedef.
- Sub-module rr_arbiter: combinational round-robin pick (req, ptr, mask_owner → one-hot winner, valid); instantiated once.

## Test plan
- Requester 2 alone, 3 read beats at addr 0x10..0x12 with SRAM preloaded 0xA0..0xA2 → gnt[2] one cycle after req; rvalid[2] with rdata 0xA0,0xA1,0xA2 on beats+1.
- All five req high from reset, MAX_BURST=4 → grants in order 1,2,3,4,0, each exactly 4 beats, no idle cycles between.
- Requester 0 alone, req held 10 cycles with MAX_BURST=4 → re-granted at beat 4 and 8, continuous mem_en, beat_cnt restarts.
- Owner 3 drops req after 2 beats while requester 1 waits → one cycle mem_en=0, then gnt[1].
- enable dropped during requester 4's burst → burst completes to release, then gnt=0 despite pending req; enable high → grant resumes next cycle.
- reset_n pulsed during write burst of requester 1 → gnt, rvalid, mem_en zero that cycle; after release, first grant to requester 1 (ptr=0).
